// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, register address type and zero-register index for the register file
package rf_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int ZERO_REG = 0;
    typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, busy count and issue gating; RF_BYPASS_EN lets a same-cycle writeback hide busy
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [NRD-1:0]    rd_busy,
    output logic              iss_ready,
    output logic [AW:0]       busy_cnt
);
    logic [NREG-1:0] busy_q, busy_d, busy_eff, set_vec, clr_vec;
    logic [AW:0]     cnt_q, cnt_d;
    logic            waw;

    assign clr_vec = wr_en ? NREG'(1) << wr_addr : '0;
`ifdef RF_BYPASS_EN
    assign busy_eff = busy_q & ~clr_vec;
`else
    assign busy_eff = busy_q;
`endif

    for (genvar g = 0; g < NRD; g++) begin : g_busy
        assign rd_busy[g] = busy_eff[rd_addr[g*AW +: AW]];
    end

    assign waw       = iss_rd != AW'(ZERO_REG) && busy_eff[iss_rd];
    assign iss_ready = ~|rd_busy && !waw;
    assign set_vec   = (iss_valid && iss_ready && !flush && iss_rd != AW'(ZERO_REG)) ? NREG'(1) << iss_rd : '0;
    assign busy_cnt  = cnt_q;

    // Set beats clear on the same register; the count follows the actual bit transitions
    always_comb begin
        busy_d = flush ? '0 : ((busy_q & ~clr_vec) | set_vec) & ~NREG'(1);
        cnt_d  = flush ? '0 : cnt_q + (AW+1)'(|(busy_d & ~busy_q)) - (AW+1)'(|(busy_q & ~busy_d));
    end

    // Busy vector and its population count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with busy scoreboard; define RF_BYPASS_EN for write-through forwarding
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wr_en;

    assign wr_en = we && wr_addr != AW'(ZERO_REG);

    // Writeback updates one entry; entry 0 is never written
    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wr_addr] = wr_data;
    end

    // Storage array, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[g*AW +: AW];
`ifdef RF_BYPASS_EN
        assign rd_data[g*XLEN +: XLEN] = (wr_en && a == wr_addr) ? wr_data :
                                         (a == AW'(ZERO_REG)) ? '0 : regs_q[a];
`else
        assign rd_data[g*XLEN +: XLEN] = (a == AW'(ZERO_REG)) ? '0 : regs_q[a];
`endif
    end

    rf_scoreboard #(.NREG(NREG), .NRD(NRD)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .rd_busy   (rd_busy),
        .iss_ready (iss_ready),
        .busy_cnt  (busy_cnt)
    );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random checks of regfile_scoreboard against an array-based model
module tb_regfile_scoreboard;
    import rf_pkg::*;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we;
    reg_addr_t   wr_addr;
    logic [31:0] wr_data;
    logic        iss_valid;
    reg_addr_t   iss_rd;
    logic        iss_ready;
    logic        flush;
    logic [5:0]  busy_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile_scoreboard dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit m_wen();
        return we && wr_addr != 0;
    endfunction

    function automatic logic [31:0] e_data(input reg_addr_t a);
        if (a == 0) return 32'd0;
        if (BYP && m_wen() && a == wr_addr) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit e_busy(input reg_addr_t a);
        return a != 0 && m_busy[a] && !(BYP && m_wen() && a == wr_addr);
    endfunction

    function automatic bit e_ready();
        bit r = 1'b1;
        if (e_busy(rd_addr[4:0]) || e_busy(rd_addr[9:5])) r = 1'b0;
        if (e_busy(iss_rd)) r = 1'b0;
        return r;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int k = 0; k < 32; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_data"}, rd_data[i*32 +: 32], e_data(rd_addr[i*5 +: 5]));
            chk({tag, "_busy"}, 32'(rd_busy[i]), 32'(e_busy(rd_addr[i*5 +: 5])));
        end
        chk({tag, "_ready"}, 32'(iss_ready), 32'(e_ready()));
        chk({tag, "_cnt"}, 32'(busy_cnt), 32'(m_cnt()));
    endtask

    task automatic drive(input string tag, input reg_addr_t a0, input reg_addr_t a1, input logic w,
                         input reg_addr_t wa, input logic [31:0] wd, input logic v,
                         input reg_addr_t ir, input logic f);
        bit rdy;
        rd_addr = {a1, a0}; we = w; wr_addr = wa; wr_data = wd;
        iss_valid = v; iss_rd = ir; flush = f;
        #1;
        check_all(tag);
        rdy = e_ready();
        @(posedge clk);
        if (m_wen()) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (flush) for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
        else if (iss_valid && rdy && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive("wr5",   5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        drive("rd5",   5, 0, 0, 0, 0, 0, 0, 0);
        drive("x0wr",  0, 5, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
        drive("x0rd",  0, 0, 0, 0, 0, 0, 0, 0);
        drive("iss7",  0, 0, 0, 0, 0, 1, 7, 0);
        drive("raw7",  7, 0, 0, 0, 0, 1, 8, 0);
        drive("wb7",   7, 0, 1, 7, 32'h12, 0, 0, 0);
        drive("rd7",   7, 0, 0, 0, 0, 0, 0, 0);
        drive("iss3",  0, 0, 0, 0, 0, 1, 3, 0);
        drive("waw3",  0, 0, 0, 0, 0, 1, 3, 0);
        drive("sim3",  0, 0, 1, 3, 32'h33, 1, 3, 0);
        drive("post3", 3, 0, 0, 0, 0, 0, 0, 0);
        drive("wbnb",  3, 0, 1, 3, 32'h34, 0, 0, 0);
        drive("iss1",  0, 0, 0, 0, 0, 1, 1, 0);
        drive("iss2",  0, 0, 0, 0, 0, 1, 2, 0);
        drive("iss4",  0, 0, 0, 0, 0, 1, 4, 0);
        drive("flush", 0, 0, 1, 2, 32'h55, 1, 9, 1);
        drive("postf", 9, 2, 0, 0, 0, 0, 0, 0);
        drive("issa",  0, 0, 0, 0, 0, 1, 10, 0);
        drive("issb",  0, 0, 0, 0, 0, 1, 11, 0);
        rd_addr = {5'd11, 5'd10}; we = 1'b1; wr_addr = 12; wr_data = 32'h77;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
        #1;
        check_all("preasync");
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async");
        @(posedge clk);
        #1;
        check_all("inrst");
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;
        drive("wr12",  12, 5, 1, 12, 32'h77, 0, 0, 0);
        drive("rd12",  12, 5, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++)
            drive("rand", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 0,
                  5'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
